// File: rtl/layer_compositor.sv
// Two-stage layered pixel compositor: priority select over a background with
// optional 50/50 blend, frame-synchronous mask shadowing and overlap statistics.
module layer_compositor #(
  parameter int NUM_LAYERS = 8,
  parameter int CH_W       = 4,
  parameter int SYNC_W     = 2,
  parameter int COLL_W     = 20
) (
  input  logic                                 clk65,
  input  logic                                 reset_n,
  input  logic [NUM_LAYERS*(3*CH_W+1)-1:0]     layer_pix,
  input  logic [3*CH_W-1:0]                    bg_pix,
  input  logic                                 in_valid,
  input  logic                                 in_blank,
  input  logic [SYNC_W-1:0]                    in_sync,
  input  logic                                 frame_start,
  input  logic [NUM_LAYERS-1:0]                en_next,
  input  logic [NUM_LAYERS-1:0]                blend_next,
  input  logic                                 mask_load,
  output logic [3*CH_W-1:0]                    pixel,
  output logic                                 out_valid,
  output logic                                 out_blank,
  output logic [SYNC_W-1:0]                    out_sync,
  output logic [NUM_LAYERS-1:0]                en_active,
  output logic [NUM_LAYERS-1:0]                blend_active,
  output logic [COLL_W-1:0]                    overlap_count
);
  localparam int PIX_W   = 3 * CH_W;
  localparam int SLICE_W = PIX_W + 1;
  localparam int IDX_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [PIX_W-1:0]      layer_col [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] opaque;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_unpack
    assign layer_col[g] = layer_pix[g*SLICE_W +: PIX_W];
    assign opaque[g]    = layer_pix[g*SLICE_W + PIX_W];
  end

  logic [NUM_LAYERS-1:0] en_pend, blend_pend, en_act, blend_act;
  logic [NUM_LAYERS-1:0] en_eff, blend_eff, hit, hit_rest;

  // The frame_start pixel already sees the incoming masks; a coincident
  // mask_load bypasses the pending registers.
  always_comb begin
    en_eff    = en_act;
    blend_eff = blend_act;
    if (frame_start) begin
      en_eff    = mask_load ? en_next    : en_pend;
      blend_eff = mask_load ? blend_next : blend_pend;
    end
  end

  assign hit = opaque & en_eff;

  logic             w_found, u_found, w_blend;
  logic [IDX_W-1:0] w_idx, u_idx;
  logic [PIX_W-1:0] w_col, u_col;

  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    u_found  = 1'b0;
    u_idx    = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
    hit_rest = hit;
    if (w_found) hit_rest[w_idx] = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_rest[i]) begin
        u_found = 1'b1;
        u_idx   = IDX_W'(i);
      end
    end
    w_col   = w_found ? layer_col[w_idx] : bg_pix;
    u_col   = u_found ? layer_col[u_idx] : bg_pix;
    w_blend = w_found & blend_eff[w_idx];
  end

  logic overlap;
  assign overlap = in_valid & ~in_blank & (|(hit & (hit - NUM_LAYERS'(1))));

  always_ff @(posedge clk65) begin
    if (!reset_n) begin
      en_pend    <= '1;
      blend_pend <= '0;
      en_act     <= '1;
      blend_act  <= '0;
    end else begin
      if (mask_load) begin
        en_pend    <= en_next;
        blend_pend <= blend_next;
      end
      if (frame_start) begin
        en_act    <= en_eff;
        blend_act <= blend_eff;
      end
    end
  end

  assign en_active    = en_act;
  assign blend_active = blend_act;

  logic [PIX_W-1:0]  s1_w_col, s1_u_col;
  logic              s1_blend, s1_valid, s1_blank;
  logic [SYNC_W-1:0] s1_sync;

  // Stage 1 blank resets high so the output stays blanked until real pixels arrive.
  always_ff @(posedge clk65) begin
    if (!reset_n) begin
      s1_w_col <= '0;
      s1_u_col <= '0;
      s1_blend <= 1'b0;
      s1_valid <= 1'b0;
      s1_blank <= 1'b1;
      s1_sync  <= '0;
    end else begin
      s1_w_col <= w_col;
      s1_u_col <= u_col;
      s1_blend <= w_blend;
      s1_valid <= in_valid;
      s1_blank <= in_blank;
      s1_sync  <= in_sync;
    end
  end

  logic [PIX_W-1:0] blend_pix, next_pix;
  logic [CH_W:0]    ch_sum;

  always_comb begin
    blend_pix = '0;
    ch_sum    = '0;
    for (int c = 0; c < 3; c++) begin
      ch_sum = {1'b0, s1_w_col[c*CH_W +: CH_W]} + {1'b0, s1_u_col[c*CH_W +: CH_W]};
      blend_pix[c*CH_W +: CH_W] = ch_sum[CH_W:1];
    end
    if (!s1_valid || s1_blank) next_pix = '0;
    else if (s1_blend)         next_pix = blend_pix;
    else                       next_pix = s1_w_col;
  end

  always_ff @(posedge clk65) begin
    if (!reset_n) begin
      pixel     <= '0;
      out_valid <= 1'b0;
      out_blank <= 1'b1;
      out_sync  <= '0;
    end else begin
      pixel     <= next_pix;
      out_valid <= s1_valid;
      out_blank <= s1_blank;
      out_sync  <= s1_sync;
    end
  end

  logic [COLL_W-1:0] ovl_cnt;
  logic              seen_frame;

  // Overlaps seen before the first frame boundary are never published.
  always_ff @(posedge clk65) begin
    if (!reset_n) begin
      ovl_cnt       <= '0;
      overlap_count <= '0;
      seen_frame    <= 1'b0;
    end else if (frame_start) begin
      overlap_count <= seen_frame ? ovl_cnt : '0;
      ovl_cnt       <= overlap ? COLL_W'(1) : '0;
      seen_frame    <= 1'b1;
    end else if (overlap && (ovl_cnt != '1)) begin
      ovl_cnt <= ovl_cnt + COLL_W'(1);
    end
  end
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: a cycle-level reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_layer_compositor;
  localparam int NL = 8;
  localparam int CW = 4;
  localparam int PW = 3 * CW;
  localparam int SW = 2;

  logic clk65 = 1'b0;
  always #5 clk65 = ~clk65;

  logic                  reset_n;
  logic [NL*(PW+1)-1:0]  layer_pix;
  logic [PW-1:0]         bg_pix;
  logic                  in_valid, in_blank, frame_start, mask_load;
  logic [SW-1:0]         in_sync;
  logic [NL-1:0]         en_next, blend_next;
  logic [PW-1:0]         pixel;
  logic                  out_valid, out_blank;
  logic [SW-1:0]         out_sync;
  logic [NL-1:0]         en_active, blend_active;
  logic [19:0]           overlap_count;

  logic [PW-1:0]         pixel_b;
  logic                  valid_b, blank_b;
  logic [SW-1:0]         sync_b;
  logic [NL-1:0]         en_b, blend_b;
  logic [3:0]            overlap_count4;

  layer_compositor #(.NUM_LAYERS(NL), .CH_W(CW), .SYNC_W(SW), .COLL_W(20)) dut (
    .clk65(clk65), .reset_n(reset_n), .layer_pix(layer_pix), .bg_pix(bg_pix),
    .in_valid(in_valid), .in_blank(in_blank), .in_sync(in_sync),
    .frame_start(frame_start), .en_next(en_next), .blend_next(blend_next),
    .mask_load(mask_load), .pixel(pixel), .out_valid(out_valid),
    .out_blank(out_blank), .out_sync(out_sync), .en_active(en_active),
    .blend_active(blend_active), .overlap_count(overlap_count)
  );

  layer_compositor #(.NUM_LAYERS(NL), .CH_W(CW), .SYNC_W(SW), .COLL_W(4)) dut4 (
    .clk65(clk65), .reset_n(reset_n), .layer_pix(layer_pix), .bg_pix(bg_pix),
    .in_valid(in_valid), .in_blank(in_blank), .in_sync(in_sync),
    .frame_start(frame_start), .en_next(en_next), .blend_next(blend_next),
    .mask_load(mask_load), .pixel(pixel_b), .out_valid(valid_b),
    .out_blank(blank_b), .out_sync(sync_b), .en_active(en_b),
    .blend_active(blend_b), .overlap_count(overlap_count4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct {
    logic [PW-1:0] pix;
    logic          valid;
    logic          blank;
    logic [SW-1:0] sync;
  } out_t;

  out_t          pipe_q[$];
  out_t          exp_out, r;
  logic [NL-1:0] m_en_pend, m_bl_pend, m_en_act, m_bl_act, m_en, m_bl;
  longint        m_cnt;
  bit            m_seen, m_ovl;
  logic [19:0]   exp_cnt20;
  logic [3:0]    exp_cnt4;
  int            hits[$];
  logic [PW-1:0] col_w, col_u;
  bit            checking = 1'b0;

  function automatic out_t reset_out();
    out_t o;
    o.pix = '0; o.valid = 1'b0; o.blank = 1'b1; o.sync = '0;
    return o;
  endfunction

  function automatic logic [PW-1:0] avg(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] res;
    int ca, cb;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      ca = int'(a[c*CW +: CW]);
      cb = int'(b[c*CW +: CW]);
      res[c*CW +: CW] = CW'((ca + cb) / 2);
    end
    return res;
  endfunction

  always @(posedge clk65) begin
    if (!reset_n) begin
      m_en_pend = '1; m_bl_pend = '0; m_en_act = '1; m_bl_act = '0;
      m_cnt = 0; m_seen = 1'b0; exp_cnt20 = '0; exp_cnt4 = '0;
      exp_out = reset_out();
      pipe_q = {};
      pipe_q.push_back(reset_out());
    end else begin
      if (frame_start) begin
        m_en = mask_load ? en_next : m_en_pend;
        m_bl = mask_load ? blend_next : m_bl_pend;
      end else begin
        m_en = m_en_act;
        m_bl = m_bl_act;
      end
      hits = {};
      for (int i = 0; i < NL; i++)
        if (layer_pix[i*(PW+1) + PW] && m_en[i]) hits.push_back(i);
      col_w = (hits.size() > 0) ? layer_pix[hits[0]*(PW+1) +: PW] : bg_pix;
      col_u = (hits.size() > 1) ? layer_pix[hits[1]*(PW+1) +: PW] : bg_pix;
      r.valid = in_valid;
      r.blank = in_blank;
      r.sync  = in_sync;
      if (!in_valid || in_blank) r.pix = '0;
      else if (hits.size() > 0 && m_bl[hits[0]]) r.pix = avg(col_w, col_u);
      else r.pix = col_w;
      exp_out = pipe_q.pop_front();
      pipe_q.push_back(r);
      m_ovl = in_valid && !in_blank && (hits.size() >= 2);
      if (frame_start) begin
        exp_cnt20 = !m_seen ? 20'd0 : (m_cnt > 64'd1048575) ? 20'hFFFFF : 20'(m_cnt);
        exp_cnt4  = !m_seen ? 4'd0 : (m_cnt > 64'd15) ? 4'hF : 4'(m_cnt);
        m_cnt    = m_ovl ? 1 : 0;
        m_seen   = 1'b1;
        m_en_act = m_en;
        m_bl_act = m_bl;
      end else if (m_ovl) begin
        m_cnt = m_cnt + 1;
      end
      if (mask_load) begin
        m_en_pend = en_next;
        m_bl_pend = blend_next;
      end
    end
  end

  always @(negedge clk65) begin
    if (checking) begin
      chk("pixel", 32'(pixel), 32'(exp_out.pix));
      chk("out_valid", 32'(out_valid), 32'(exp_out.valid));
      chk("out_blank", 32'(out_blank), 32'(exp_out.blank));
      chk("out_sync", 32'(out_sync), 32'(exp_out.sync));
      chk("en_active", 32'(en_active), 32'(m_en_act));
      chk("blend_active", 32'(blend_active), 32'(m_bl_act));
      chk("overlap_count", 32'(overlap_count), 32'(exp_cnt20));
      chk("overlap_count4", 32'(overlap_count4), 32'(exp_cnt4));
    end
  end

  // Driver
  task automatic tick();
    @(negedge clk65);
    in_sync = in_sync + 2'd1;
  endtask

  task automatic set_layer(input int i, input logic op, input logic [PW-1:0] col);
    layer_pix[i*(PW+1) +: PW+1] = {op, col};
  endtask

  logic [SW-1:0] sync0;

  initial begin
    reset_n = 1'b0; layer_pix = '0; bg_pix = 12'h00F; in_valid = 1'b0;
    in_blank = 1'b1; in_sync = '0; frame_start = 1'b0; en_next = '0;
    blend_next = '0; mask_load = 1'b0;
    tick();
    checking = 1'b1;
    tick();
    chk("rst_pixel", 32'(pixel), 32'h0);
    chk("rst_blank", 32'(out_blank), 32'h1);
    chk("rst_en", 32'(en_active), 32'hFF);
    chk("rst_blend", 32'(blend_active), 32'h0);
    chk("rst_ovl", 32'(overlap_count), 32'h0);

    // Priority: layer 2 beats layer 5
    set_layer(2, 1'b1, 12'hF00);
    set_layer(5, 1'b1, 12'h0F0);
    in_valid = 1'b1; in_blank = 1'b0; reset_n = 1'b1; frame_start = 1'b1;
    sync0 = in_sync;
    tick();
    frame_start = 1'b0;
    tick();
    chk("prio_pixel", 32'(pixel), 32'hF00);
    chk("prio_sync", 32'(out_sync), 32'(sync0));

    // Enable change mid-frame stays pending
    en_next = 8'hFB; blend_next = 8'h00; mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    repeat (3) tick();
    chk("shadow_pixel", 32'(pixel), 32'hF00);
    chk("shadow_en", 32'(en_active), 32'hFF);
    frame_start = 1'b1;
    tick();
    chk("swap_en", 32'(en_active), 32'hFB);
    frame_start = 1'b0;
    tick();
    chk("swap_pixel", 32'(pixel), 32'h0F0);

    // Blend, with mask_load coinciding with frame_start
    set_layer(5, 1'b1, 12'h0F1);
    en_next = 8'hFF; blend_next = 8'h04; mask_load = 1'b1; frame_start = 1'b1;
    tick();
    mask_load = 1'b0; frame_start = 1'b0;
    chk("blend_act", 32'(blend_active), 32'h04);
    tick();
    chk("blend_pixel", 32'(pixel), 32'h770);
    set_layer(5, 1'b0, 12'h0F1);
    repeat (2) tick();
    chk("blend_bg_pixel", 32'(pixel), 32'h707);

    // Blank and valid gating
    set_layer(5, 1'b1, 12'h0F0);
    in_blank = 1'b1;
    repeat (2) tick();
    chk("blank_pixel", 32'(pixel), 32'h0);
    chk("blank_flag", 32'(out_blank), 32'h1);
    in_blank = 1'b0; in_valid = 1'b0;
    repeat (2) tick();
    chk("novalid_pixel", 32'(pixel), 32'h0);
    chk("novalid_flag", 32'(out_valid), 32'h0);
    in_valid = 1'b1;

    // Overlap counting: 37 overlaps in one frame
    frame_start = 1'b1; in_blank = 1'b1;
    tick();
    frame_start = 1'b0; in_blank = 1'b0;
    repeat (37) tick();
    set_layer(5, 1'b0, 12'h0F0);
    repeat (3) tick();
    set_layer(5, 1'b1, 12'h0F0);
    frame_start = 1'b1;
    tick();
    chk("ovl_37", 32'(overlap_count), 32'd37);
    chk("ovl_sat4", 32'(overlap_count4), 32'd15);
    frame_start = 1'b0;
    set_layer(5, 1'b0, 12'h0F0);
    repeat (5) tick();
    frame_start = 1'b1;
    tick();
    chk("ovl_fs_pixel", 32'(overlap_count), 32'd1);
    frame_start = 1'b0;

    // Reset in the middle of active pixels
    set_layer(5, 1'b1, 12'h0F0);
    en_next = 8'h01; mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_pixel", 32'(pixel), 32'h0);
    chk("mid_rst_blank", 32'(out_blank), 32'h1);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_en", 32'(en_active), 32'hFF);
    chk("mid_rst_blend", 32'(blend_active), 32'h0);
    chk("mid_rst_ovl", 32'(overlap_count), 32'h0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_pixel", 32'(pixel), 32'hF00);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("post_rst_en", 32'(en_active), 32'hFF);
    repeat (3) tick();

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed eight-layer priority pixel mux between the sprite/string/menu generators and the VGA output.
- Selects the highest-priority enabled, opaque layer over a background. Optionally 50/50 blends the winner with the layer beneath it.
- Delays sync/blank sideband to stay aligned with the pixel.
- Layer-enable and blend masks are double-buffered and swap only at frame start. Per-frame overlap statistics are reported for debug.

Parameters:
- NUM_LAYERS, 8, number of overlay layers; layer 0 has the highest priority.
- CH_W, 4, bits per colour channel; pixel width PIX_W = 3*CH_W (R,G,B from MSB down).
- SYNC_W, 2, sideband bits delayed alongside the pixel (hsync, vsync).
- COLL_W, 20, width of the saturating overlap counter.

Ports:
- clk65  in  1  pixel clock.
- reset_n  in  1  synchronous, active-low reset.
- layer_pix  in  NUM_LAYERS*(PIX_W+1)  layer i occupies bits [i*(PIX_W+1) +: PIX_W+1]; the MSB of each slice is opaque/use flag, the remainder is colour.
- bg_pix  in  PIX_W  background colour, always opaque.
- in_valid  in  1  pixel qualifier.
- in_blank  in  1  outside active video.
- in_sync  in  SYNC_W  sideband to delay.
- frame_start  in  1  one-cycle pulse on the first pixel of a frame.
- en_next  in  NUM_LAYERS  pending layer-enable mask.
- blend_next  in  NUM_LAYERS  pending blend mask.
- mask_load  in  1  captures en_next/blend_next into the pending registers.
- pixel  out  PIX_W  composited colour.
- out_valid  out  1  delayed in_valid.
- out_blank  out  1  delayed in_blank.
- out_sync  out  SYNC_W  delayed in_sync.
- en_active  out  NUM_LAYERS  currently applied enable mask.
- blend_active  out  NUM_LAYERS  currently applied blend mask.
- overlap_count  out  COLL_W  overlap total of the previous frame.

Behaviour:
- Streaming, no backpressure; the pipeline advances every cycle. Latency is exactly 2 cycles for pixel, out_valid, out_blank and out_sync, including when in_valid=0.
- Reset (reset_n=0 at a clk65 edge) sets:
  - pixel=0, out_valid=0, out_blank=1, out_sync=0;
  - en_active and pending enable = all ones;
  - blend_active and pending blend = 0;
  - overlap counter=0, overlap_count=0;
  - all pipeline registers cleared.
- Reset mid-frame discards in-flight pixels. Outputs resume 2 cycles after reset_n rises.
- Mask shadowing:
  - mask_load writes the pending registers.
  - On frame_start, pending is copied to active, and the active mask is used for that same pixel.
  - If mask_load and frame_start coincide, the new en_next/blend_next values go straight to active for that pixel.
  - mask_load without frame_start never changes active masks mid-frame.
- Stage 1 (registered):
  - hit[i] = opaque[i] & en_mask[i].
  - W = lowest i with hit, else background.
  - U = next lowest hit index after W, else background.
  - Register colour(W), colour(U), blend_mask[W] (0 for background) and the sideband.
- Stage 2 (registered):
  - If in_blank or in_valid was 0, pixel=0.
  - Else if the registered blend bit is set, each channel = (cW + cU) >> 1, computed in CH_W+1 bits and truncating (floor).
  - Else pixel = colour(W).
- Overlap statistics:
  - A pixel with in_valid=1, in_blank=0 and two or more hits increments the counter, saturating at 2^COLL_W-1.
  - On frame_start, overlap_count <= counter value (including the pixel of the previous cycle). The counter then restarts at 0, plus 1 if the frame_start pixel itself overlaps.
- The first frame_start after reset publishes 0. overlap_count is stable between frame_starts.
- With NUM_LAYERS=8 and CH_W=4, blending masks disabled, the output equals the legacy fixed mux delayed by 2 cycles.

Test Plan:
- Priority: layers 2 and 5 opaque (0xF00, 0x0F0), bg 0x00F, masks reset -> pixel 0xF00 exactly 2 cycles later, with out_sync matching the input delayed by 2.
- Enable shadowing: mask_load with en_next=0xFB mid-frame -> output stays 0xF00 until the next frame_start pixel, then becomes 0x0F0. en_active changes on that same edge.
- Blend: blend bit 2 active, layer 2=0xF00, layer 5=0x0F1 -> pixel 0x770. With layer 5 transparent and bg 0x00F -> 0x707.
- Blank/valid gating: in_blank=1 with opaque layers -> pixel 0, out_blank=1. in_valid=0 -> pixel 0, out_valid=0. Neither increments the overlap counter.
- Overlap counting: 37 overlapping active pixels in frame, then frame_start -> overlap_count=37. Overlap on the frame_start pixel -> next frame reports at least 1. COLL_W=4 with 20 overlaps -> 15.
- Reset mid-stream: reset_n low for 1 cycle during active pixels -> next-edge outputs are 0 / out_blank=1, masks back to all-ones/zero, overlap_count=0.
